length_accumulator_pipe: RTL and testbench
==========================================

Name: length_accumulator_pipe

Overview:
- Parametrised successor to the compression-stage length accumulator.
- Accepts a stream of variable-length code tokens (bit counts) with a valid/ready handshake, and tracks word fill and line fill.
- Emits registered per-token packing control to the word packer: store/shift/send-back.
- Adds end-of-line flush with padding, per-line bit and word counts, downstream backpressure, and illegal-length detection.

Parameters:
- WORD_SIZE, 64, packed word width in bits; power of two, at least 8.
- LINE_SIZE, 128, cache-line width in bits; integer multiple of WORD_SIZE.
- LEN_W, 7, width of i_length; must satisfy 2^LEN_W-1 >= WORD_SIZE.
- TOT_W, 16, width of the per-line bit counter o_line_bits.
- CNT_W, 8, width of the per-line stored-word counter o_word_count.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  token valid.
- o_ready  out  1  token accepted when i_valid && o_ready.
- i_length  in  LEN_W  code length in bits, legal range 0..WORD_SIZE.
- i_last  in  1  token is the last of the current line.
- o_valid  out  1  output record valid.
- i_ready  in  1  downstream accepts the record when o_valid && i_ready.
- o_store_flag  out  1  a word completed; packer stores it.
- o_shift_amount  out  clog2(WORD_SIZE)  residual bits in the current word after this token.
- o_send_back  out  1  running line sum crossed a LINE_SIZE boundary.
- o_pad  out  1  record is a flush/pad record, not a token.
- o_pad_bits  out  clog2(WORD_SIZE)+1  zero bits appended by the flush.
- o_line_done  out  1  last record of the line.
- o_line_bits  out  TOT_W  data bits in the line (pad excluded), saturating.
- o_word_count  out  CNT_W  words stored in the line, including the pad word; saturating.
- o_err  out  1  sticky: an illegal length was seen.

Behaviour:
- Reset: all outputs 0, internal partial/total/counters 0, state ACCUM. o_ready is 1 from the first cycle after reset deasserts.
- Reset during any state (including FLUSH) aborts immediately; no pad record is ever emitted after reset.
- States: ACCUM and FLUSH.
- o_ready = (state==ACCUM) && (!o_valid || i_ready).
- Output stability: the output register loads only when empty or being drained. While o_valid && !i_ready, all outputs hold stable.
- Latency: a record appears one cycle after token acceptance.
- Accepted token, len L (L > WORD_SIZE sets o_err and is treated as WORD_SIZE):
  - np = partial + L.
  - store = np >= WORD_SIZE; shift = store ? np-WORD_SIZE : np; partial <= shift.
  - nt = total + L; send_back = nt >= LINE_SIZE; total <= send_back ? nt-LINE_SIZE : nt.
  - line_bits += L, saturating; word_count += store, saturating.
  - Record: o_pad=0, o_pad_bits=0.
- i_last on an accepted token:
  - If the resulting shift==0: the token's record carries o_line_done=1 with final counts. Then partial, total, line_bits and word_count clear; state stays ACCUM.
  - If shift!=0: the token's record has o_line_done=0, and state goes to FLUSH.
- FLUSH (o_ready=0): when the output register can load, emit a pad record:
  - o_pad=1, o_store_flag=1, o_pad_bits=WORD_SIZE-partial, o_shift_amount=0.
  - o_send_back=1 iff total+pad_bits >= LINE_SIZE.
  - o_word_count incremented; o_line_bits unchanged; o_line_done=1.
  - Clear partial, total and counters; return to ACCUM.
- Widths: internal sums are computed one bit wider than max(WORD_SIZE, LINE_SIZE)+WORD_SIZE, so they never wrap.
- o_err clears only on reset.

Test Plan:
- Reset asserted mid-stream -> every output 0 the same cycle; o_ready=1 the cycle after release; first new token computes from partial=0.
- Tokens 40, 30, 58 (i_ready=1):
  - 40 -> store=0, shift=40.
  - 30 -> store=1, shift=6, send_back=0.
  - 58 -> store=1, shift=0, send_back=1.
- Tokens 20, then 10 with i_last:
  - 20 -> shift=20.
  - 10 -> shift=30, line_done=0.
  - Next cycle: pad record, store=1, pad=1, pad_bits=34, line_done=1, line_bits=30, word_count=1.
  - o_ready=0 during FLUSH; counters then 0.
- Tokens 64 with i_last -> store=1, shift=0, line_done=1, word_count=1, no pad record.
- i_ready=0 for 3 cycles with o_valid=1 -> outputs frozen, o_ready=0, no token accepted; on release, the held record drains and the next token is accepted.
- i_length=100 after partial=10 -> o_err=1 (sticky), record store=1, shift=10.

Source files
------------

// File: rtl/length_accumulator_pipe_if.sv
// Token-in / packing-record-out bundle for the length accumulator.
// The DUT takes the slave view, the producer/consumer pair the master view.
interface length_accumulator_pipe_if #(
  parameter int WORD_SIZE = 64,
  parameter int LEN_W     = 7,
  parameter int TOT_W     = 16,
  parameter int CNT_W     = 8
);
  localparam int SHW = $clog2(WORD_SIZE);

  logic             i_valid;
  logic             o_ready;
  logic [LEN_W-1:0] i_length;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic             o_store_flag;
  logic [SHW-1:0]   o_shift_amount;
  logic             o_send_back;
  logic             o_pad;
  logic [SHW:0]     o_pad_bits;
  logic             o_line_done;
  logic [TOT_W-1:0] o_line_bits;
  logic [CNT_W-1:0] o_word_count;
  logic             o_err;

  modport slave (
    input  i_valid, i_length, i_last, i_ready,
    output o_ready, o_valid, o_store_flag, o_shift_amount,
    output o_send_back, o_pad, o_pad_bits, o_line_done,
    output o_line_bits, o_word_count, o_err
  );

  modport master (
    output i_valid, i_length, i_last, i_ready,
    input  o_ready, o_valid, o_store_flag, o_shift_amount,
    input  o_send_back, o_pad, o_pad_bits, o_line_done,
    input  o_line_bits, o_word_count, o_err
  );
endinterface

// File: rtl/length_accumulator_pipe.sv
// Tracks word and line fill for a stream of code lengths and emits
// registered store/shift/send-back records, padding lines to a word.
module length_accumulator_pipe #(
  parameter int WORD_SIZE = 64,
  parameter int LINE_SIZE = 128,
  parameter int LEN_W     = 7,
  parameter int TOT_W     = 16,
  parameter int CNT_W     = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  length_accumulator_pipe_if.slave bus
);
  localparam int SHW  = $clog2(WORD_SIZE);
  localparam int MAXV = (WORD_SIZE > LINE_SIZE) ? WORD_SIZE : LINE_SIZE;
  localparam int SW   = $clog2(MAXV + WORD_SIZE + 1) + 1;

  localparam logic [LEN_W-1:0] W_LEN  = LEN_W'(WORD_SIZE);
  localparam logic [SHW:0]     W_BITS = (SHW+1)'(WORD_SIZE);
  localparam logic [SW-1:0]    LINE_S = SW'(LINE_SIZE);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   part_q, part_d;
  logic [SW-1:0]    tot_q, tot_d;
  logic [TOT_W-1:0] lbits_q, lbits_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             err_q, err_d;

  logic             vld_q, vld_d;
  logic             store_q, store_d;
  logic [SHW-1:0]   shift_q, shift_d;
  logic             sb_q, sb_d;
  logic             pad_q, pad_d;
  logic [SHW:0]     padb_q, padb_d;
  logic             done_q, done_d;
  logic [TOT_W-1:0] obits_q, obits_d;
  logic [CNT_W-1:0] ocnt_q, ocnt_d;

  logic             ready_c, take, flush_go, too_long;
  logic [SHW:0]     len_c, np, pb;
  logic [SHW-1:0]   sh;
  logic             st, sb, psb;
  logic [SW-1:0]    nt, ntot;
  logic [TOT_W:0]   lsum;
  logic [TOT_W-1:0] lsat;
  logic [CNT_W-1:0] winc, wnext;

  assign ready_c = !i_reset && (state_q == ACCUM) && (!vld_q || bus.i_ready);
  assign take     = bus.i_valid && ready_c;
  assign flush_go = (state_q == FLUSH) && (!vld_q || bus.i_ready);

  always_comb begin
    state_d  = state_q;
    part_d   = part_q;
    tot_d    = tot_q;
    lbits_d  = lbits_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    vld_d    = vld_q;
    store_d  = store_q;
    shift_d  = shift_q;
    sb_d     = sb_q;
    pad_d    = pad_q;
    padb_d   = padb_q;
    done_d   = done_q;
    obits_d  = obits_q;
    ocnt_d   = ocnt_q;

    // Over-long codes are clamped to a full word.
    too_long = bus.i_length > W_LEN;
    len_c    = too_long ? W_BITS : bus.i_length[SHW:0];
    np       = {1'b0, part_q} + len_c;
    st       = np[SHW];
    sh       = np[SHW-1:0];
    nt       = tot_q + SW'(len_c);
    sb       = nt >= LINE_S;
    ntot     = sb ? nt - LINE_S : nt;
    lsum     = {1'b0, lbits_q} + (TOT_W+1)'(len_c);
    lsat     = lsum[TOT_W] ? '1 : lsum[TOT_W-1:0];
    winc     = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
    wnext    = st ? winc : wcnt_q;
    pb       = W_BITS - {1'b0, part_q};
    psb      = (tot_q + SW'(pb)) >= LINE_S;

    if (vld_q && bus.i_ready) vld_d = 1'b0;

    unique case (1'b1)
      take: begin
        err_d   = err_q | too_long;
        vld_d   = 1'b1;
        store_d = st;
        shift_d = sh;
        sb_d    = sb;
        pad_d   = 1'b0;
        padb_d  = '0;
        done_d  = 1'b0;
        obits_d = lsat;
        ocnt_d  = wnext;
        part_d  = sh;
        tot_d   = ntot;
        lbits_d = lsat;
        wcnt_d  = wnext;
        if (bus.i_last && sh == '0) begin
          done_d  = 1'b1;
          part_d  = '0;
          tot_d   = '0;
          lbits_d = '0;
          wcnt_d  = '0;
        end else if (bus.i_last) begin
          state_d = FLUSH;
        end
      end
      flush_go: begin
        vld_d   = 1'b1;
        store_d = 1'b1;
        shift_d = '0;
        sb_d    = psb;
        pad_d   = 1'b1;
        padb_d  = pb;
        done_d  = 1'b1;
        obits_d = lbits_q;
        ocnt_d  = winc;
        part_d  = '0;
        tot_d   = '0;
        lbits_d = '0;
        wcnt_d  = '0;
        state_d = ACCUM;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ACCUM;
      part_q  <= '0;
      tot_q   <= '0;
      lbits_q <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      store_q <= 1'b0;
      shift_q <= '0;
      sb_q    <= 1'b0;
      pad_q   <= 1'b0;
      padb_q  <= '0;
      done_q  <= 1'b0;
      obits_q <= '0;
      ocnt_q  <= '0;
    end else begin
      state_q <= state_d;
      part_q  <= part_d;
      tot_q   <= tot_d;
      lbits_q <= lbits_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      store_q <= store_d;
      shift_q <= shift_d;
      sb_q    <= sb_d;
      pad_q   <= pad_d;
      padb_q  <= padb_d;
      done_q  <= done_d;
      obits_q <= obits_d;
      ocnt_q  <= ocnt_d;
    end
  end

  assign bus.o_ready        = ready_c;
  assign bus.o_valid        = vld_q;
  assign bus.o_store_flag   = store_q;
  assign bus.o_shift_amount = shift_q;
  assign bus.o_send_back    = sb_q;
  assign bus.o_pad          = pad_q;
  assign bus.o_pad_bits     = padb_q;
  assign bus.o_line_done    = done_q;
  assign bus.o_line_bits    = obits_q;
  assign bus.o_word_count   = ocnt_q;
  assign bus.o_err          = err_q;
endmodule

// File: tb/tb_length_accumulator_pipe.sv
// Scoreboard bench: directed and random code lengths against a
// line/word arithmetic model, with random downstream backpressure.
module tb_length_accumulator_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  length_accumulator_pipe_if bus_if ();

  length_accumulator_pipe dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  typedef struct packed {
    logic        st;
    logic [5:0]  sh;
    logic        sb;
    logic        pad;
    logic [6:0]  pb;
    logic        dn;
    logic [15:0] lb;
    logic [7:0]  wc;
    logic        er;
  } rec_t;

  rec_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_part, m_tot, m_lb, m_wc;
  bit   m_err;
  bit   rand_rdy = 1'b0;

  function automatic rec_t mk(bit st, int sh, bit sb, bit pad, int pb, bit dn);
    rec_t r;
    r.st  = st;
    r.sh  = 6'(sh);
    r.sb  = sb;
    r.pad = pad;
    r.pb  = 7'(pb);
    r.dn  = dn;
    r.lb  = 16'(m_lb);
    r.wc  = 8'(m_wc);
    r.er  = m_err;
    return r;
  endfunction

  function automatic void m_clear();
    m_part = 0;
    m_tot  = 0;
    m_lb   = 0;
    m_wc   = 0;
  endfunction

  // Line model: bits fill 64-bit words and 128-bit lines.
  function automatic void model(int len, bit last);
    int l, np, nt, sh, pb;
    bit st, sb;
    if (len > 64) m_err = 1'b1;
    l  = (len > 64) ? 64 : len;
    np = m_part + l;
    st = np >= 64;
    sh = st ? np - 64 : np;
    nt = m_tot + l;
    sb = nt >= 128;
    m_tot  = sb ? nt - 128 : nt;
    m_part = sh;
    m_lb   = (m_lb + l > 65535) ? 65535 : m_lb + l;
    if (st && m_wc < 255) m_wc++;
    if (last && sh == 0) begin
      q.push_back(mk(st, sh, sb, 1'b0, 0, 1'b1));
      m_clear();
    end else if (last) begin
      q.push_back(mk(st, sh, sb, 1'b0, 0, 1'b0));
      pb = 64 - m_part;
      sb = (m_tot + pb) >= 128;
      if (m_wc < 255) m_wc++;
      q.push_back(mk(1'b1, 0, sb, 1'b1, pb, 1'b1));
      m_clear();
    end else begin
      q.push_back(mk(st, sh, sb, 1'b0, 0, 1'b0));
    end
  endfunction

  function automatic rec_t dut_rec();
    rec_t r;
    r.st  = bus_if.o_store_flag;
    r.sh  = bus_if.o_shift_amount;
    r.sb  = bus_if.o_send_back;
    r.pad = bus_if.o_pad;
    r.pb  = bus_if.o_pad_bits;
    r.dn  = bus_if.o_line_done;
    r.lb  = bus_if.o_line_bits;
    r.wc  = bus_if.o_word_count;
    r.er  = bus_if.o_err;
    return r;
  endfunction

  task automatic check_zero(string name);
    logic [41:0] all;
    all = {bus_if.o_ready, bus_if.o_valid, dut_rec()};
    checks++;
    if (all !== '0) begin
      errors++;
      $display("FAIL %s outputs act=%h exp=0", name, all);
    end
  endtask

  task automatic check_ready(string name, logic exp);
    checks++;
    if (bus_if.o_ready !== exp) begin
      errors++;
      $display("FAIL %s o_ready act=%b exp=%b", name, bus_if.o_ready, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(int len, bit last);
    bit ok;
    ok = 1'b0;
    bus_if.i_valid  = 1'b1;
    bus_if.i_length = 7'(len);
    bus_if.i_last   = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_if.o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      model(len, last);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout len=%0d act=stuck exp=accepted", len);
    end
    @(posedge clk);
    #1;
    bus_if.i_valid = 1'b0;
    bus_if.i_last  = 1'b0;
  endtask

  initial begin
    rec_t a;
    forever begin
      @(negedge clk);
      if (!rst && bus_if.o_valid) begin
        a = dut_rec();
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_record act=%p exp=none", a);
        end else begin
          if (a !== q[0]) begin
            errors++;
            $display("FAIL record act=%p exp=%p", a, q[0]);
          end
          if (bus_if.i_ready) void'(q.pop_front());
        end
        if (!bus_if.i_ready) check_ready("stall", 1'b0);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus_if.i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int len;
    bit last;
    rst             = 1'b0;
    bus_if.i_valid  = 1'b0;
    bus_if.i_length = '0;
    bus_if.i_last   = 1'b0;
    bus_if.i_ready  = 1'b1;
    m_err = 1'b0;
    m_clear();
    #2 rst = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_ready("after_reset", 1'b1);
    @(posedge clk);
    #1;

    send(40, 1'b0);
    send(30, 1'b0);
    send(58, 1'b0);
    send(20, 1'b0);
    send(10, 1'b1);
    @(negedge clk);
    check_ready("flush", 1'b0);
    @(posedge clk);
    #1;
    send(64, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    bus_if.i_ready = 1'b0;
    send(16, 1'b0);
    bus_if.i_valid  = 1'b1;
    bus_if.i_length = 7'd8;
    repeat (3) @(posedge clk);
    #1 bus_if.i_ready = 1'b1;
    send(8, 1'b0);
    send(50, 1'b0);
    send(100, 1'b0);

    send(20, 1'b1);
    rst = 1'b1;
    #1 check_zero("reset_mid_flush");
    q.delete();
    m_err = 1'b0;
    m_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_ready("after_reset2", 1'b1);
    @(posedge clk);
    #1;
    send(30, 1'b0);

    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) len = $urandom_range(65, 127);
      else len = $urandom_range(0, 64);
      last = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(len, last);
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 bus_if.i_ready = 1'b1;
    for (int n = 0; n < 100 && q.size() > 0; n++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain act=%0d exp=0 pending", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
